traffic_light_monitor: RTL

- Receiving end of the controller's light/remaining_time interface: samples the 3-bit light code and 5-bit countdown.
- Drives the physical lamps and a multiplexed 2-digit 7-segment countdown display.
- Checks protocol: legal encoding, legal colour sequence, sane countdown. Raises a sticky fault with the first fault code captured.
- Runs on the same clock as the controller; one countdown step per clock at most.

---
 rtl/traffic_light_monitor.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// Receive side of the traffic controller link: drives lamps and a 2-digit countdown display, flags protocol faults.
// Optional held-input (stall) detection is compiled in with `define TRAFFIC_STALL_DETECT_EN.
module traffic_light_monitor #(
  parameter int REFRESH_DIV = 16,
  parameter int MAX_TIME    = 20,
  parameter int STALL_LIMIT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light,
  input  logic [4:0] remaining_time,
  output logic       lamp_r,
  output logic       lamp_y,
  output logic       lamp_g,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       fault,
  output logic [1:0] fault_code
);
  localparam int            CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [2:0]    RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  localparam logic [6:0]    DASH = 7'b1000000;

  if (REFRESH_DIV < 2 || STALL_LIMIT < 1) begin : g_param_chk
    $error("traffic_light_monitor: REFRESH_DIV must be >= 2 and STALL_LIMIT >= 1");
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;  4'd1: seg7 = 7'h06;  4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;  4'd4: seg7 = 7'h66;  4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;  4'd7: seg7 = 7'h07;  4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;  default: seg7 = 7'h00;
    endcase
  endfunction

  // Stage 1 sample plus the previous sample for change detection.
  logic [2:0] light_q, light_p;
  logic [4:0] time_q, time_p;
  logic       vld_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      light_q <= '0; light_p <= '0;
      time_q  <= '0; time_p  <= '0;
      vld_q   <= 1'b0;
    end else begin
      light_p <= light_q;
      time_p  <= time_q;
      light_q <= light;
      time_q  <= remaining_time;
      vld_q   <= 1'b1;
    end
  end

  logic          armed_q, fault_q;
  logic [1:0]    code_q, an_q;
  logic [2:0]    lamps_q;
  logic [6:0]    seg_q;
  logic [CW-1:0] cnt_q;

  logic legal_q, legal_p, same_light, same_time, seq_ok, step_ok;
  logic bad_enc, bad_seq, bad_time, stall_hit, fault_d;
  logic [1:0] code_d;

  always_comb begin
    legal_q    = (light_q == RED) || (light_q == YEL) || (light_q == GRN);
    legal_p    = (light_p == RED) || (light_p == YEL) || (light_p == GRN);
    same_light = (light_q == light_p);
    same_time  = (time_q == time_p);
    seq_ok     = (light_p == RED && light_q == GRN) ||
                 (light_p == GRN && light_q == YEL) ||
                 (light_p == YEL && light_q == RED);
    // A hold or a single step down; 0 -> 31 is a wrap, never a step.
    step_ok    = same_time || (time_p != 5'd0 && time_q == time_p - 5'd1);
    bad_enc    = vld_q && !legal_q;
    bad_seq    = vld_q && armed_q && legal_q && legal_p && !same_light && !seq_ok;
    bad_time   = (vld_q && armed_q && legal_q &&
                  ((int'(time_q) > MAX_TIME) || (same_light && !step_ok))) || stall_hit;
    code_d     = bad_enc ? 2'b01 : bad_seq ? 2'b10 : bad_time ? 2'b11 : 2'b00;
    fault_d    = fault_q || (code_d != 2'b00);
  end

`ifdef TRAFFIC_STALL_DETECT_EN
  localparam int SW = $clog2(STALL_LIMIT + 1);
  logic [SW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = '0;
    if (vld_q && armed_q && same_light && same_time)
      stall_d = (stall_q == SW'(STALL_LIMIT)) ? stall_q : stall_q + SW'(1);
  end
  assign stall_hit = (stall_d == SW'(STALL_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Display: segment pattern is chosen for the digit enabled on the same edge.
  logic [CW-1:0] cnt_d;
  logic [1:0]    an_d, tens;
  logic [3:0]    ones;
  logic [6:0]    seg_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    an_d  = (cnt_q == CNT_LAST) ? {an_q[0], an_q[1]} : an_q;
    tens  = (time_q >= 5'd30) ? 2'd3 : (time_q >= 5'd20) ? 2'd2 : (time_q >= 5'd10) ? 2'd1 : 2'd0;
    ones  = 4'(time_q - {tens, 3'b000} - {2'b00, tens, 1'b0});
    if (fault_d)        seg_d = DASH;
    else if (an_d[1])   seg_d = (tens == 2'd0) ? 7'h00 : seg7({2'b00, tens});
    else                seg_d = seg7(ones);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
      lamps_q <= '0;
      seg_q   <= '0;
      an_q    <= 2'b01;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_q || (vld_q && legal_q);
      fault_q <= fault_d;
      if (!fault_q && code_d != 2'b00) code_q <= code_d;
      lamps_q <= legal_q ? light_q : 3'b000;
      seg_q   <= seg_d;
      an_q    <= an_d;
      cnt_q   <= cnt_d;
    end
  end

  assign {lamp_r, lamp_y, lamp_g} = lamps_q;
  assign seg        = seg_q;
  assign an         = an_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
endmodule
